// File: rtl/exec_stage.sv
// Single-entry execute stage: ALU, flag register, branch resolution and memory-op decode.
// Define EXEC_SEG_EN to build the 7-segment display registers driven by the OUT opcode.
module exec_stage #(
    parameter int WIDTH  = 16,
    parameter int RA_W   = 3,
    parameter int NDIGIT = WIDTH / 4
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic [WIDTH-1:0]      alu1,
    input  logic [WIDTH-1:0]      alu2,
    input  logic [3:0]            opcode,
    input  logic [2:0]            cond,
    input  logic                  is_branch,
    input  logic                  write_reg,
    input  logic [RA_W-1:0]       reg_addr,
    input  logic [1:0]            mem_op,
    input  logic [WIDTH-1:0]      address,
    input  logic [WIDTH-1:0]      store_data,
    input  logic                  flush,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [WIDTH-1:0]      alu_out,
    output logic [WIDTH-1:0]      address_o,
    output logic [WIDTH-1:0]      store_data_o,
    output logic [WIDTH-1:0]      pctarget,
    output logic [RA_W-1:0]       reg_addr_o,
    output logic                  write_reg_o,
    output logic                  read_en,
    output logic                  write_en,
    output logic                  pcsrc,
    output logic [3:0]            flags_o,
    output logic [15:0]           taken_cnt,
    output logic [8*NDIGIT-1:0]   seg
);
    typedef enum logic [3:0] {
        OP_ADD = 4'd0, OP_SUB = 4'd1, OP_AND = 4'd2, OP_OR  = 4'd3,
        OP_XOR = 4'd4, OP_CMP = 4'd5, OP_MOV = 4'd6, OP_SLL = 4'd8,
        OP_SRL = 4'd9, OP_OUT = 4'd13
    } op_e;

    localparam int MSB = WIDTH - 1;

    logic              valid_q;
    logic [WIDTH-1:0]  alu_q, addr_q, sd_q;
    logic [RA_W-1:0]   ra_q;
    logic              wr_q, rd_q, we_q, pc_q;
    logic [3:0]        flags_q;
    logic [15:0]       cnt_q;

    logic              accept;
    logic [WIDTH:0]    sum_w, dif_w;
    logic [WIDTH-1:0]  res_d;
    logic              c_d, v_d, upd_d, taken_d;
    logic [3:0]        flags_d;

    assign in_ready = ~valid_q | out_ready;
    assign accept   = in_valid & in_ready & ~flush;
    assign sum_w    = {1'b0, alu1} + {1'b0, alu2};
    // Top bit of the zero-extended difference is the borrow.
    assign dif_w    = {1'b0, alu1} - {1'b0, alu2};

    always_comb begin
        res_d = '0;
        c_d   = 1'b0;
        v_d   = 1'b0;
        upd_d = 1'b0;
        case (opcode)
            OP_ADD: begin
                res_d = sum_w[MSB:0];
                c_d   = sum_w[WIDTH];
                v_d   = (alu1[MSB] == alu2[MSB]) && (sum_w[MSB] != alu1[MSB]);
                upd_d = 1'b1;
            end
            OP_SUB, OP_CMP: begin
                res_d = dif_w[MSB:0];
                c_d   = dif_w[WIDTH];
                v_d   = (alu1[MSB] != alu2[MSB]) && (dif_w[MSB] != alu1[MSB]);
                upd_d = 1'b1;
            end
            OP_AND: begin res_d = alu1 & alu2;       upd_d = 1'b1; end
            OP_OR:  begin res_d = alu1 | alu2;       upd_d = 1'b1; end
            OP_XOR: begin res_d = alu1 ^ alu2;       upd_d = 1'b1; end
            OP_SLL: begin res_d = alu1 << alu2[3:0]; upd_d = 1'b1; end
            OP_SRL: begin res_d = alu1 >> alu2[3:0]; upd_d = 1'b1; end
            OP_MOV: res_d = alu2;
            OP_OUT: res_d = alu1;
            default: res_d = '0;
        endcase
        flags_d = {res_d[MSB], res_d == '0, c_d, v_d};
    end

    // Branch decision sees the flags committed by earlier instructions only.
    always_comb begin
        taken_d = 1'b0;
        case (cond)
            3'd0: taken_d = flags_q[2];
            3'd1: taken_d = flags_q[3] ^ flags_q[0];
            3'd2: taken_d = flags_q[2] | (flags_q[3] ^ flags_q[0]);
            3'd3: taken_d = ~flags_q[2];
            3'd4: taken_d = 1'b1;
            3'd5: taken_d = ~(flags_q[3] ^ flags_q[0]);
            default: taken_d = 1'b0;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            valid_q <= 1'b0;
            alu_q   <= '0;
            addr_q  <= '0;
            sd_q    <= '0;
            ra_q    <= '0;
            wr_q    <= 1'b0;
            rd_q    <= 1'b0;
            we_q    <= 1'b0;
            pc_q    <= 1'b0;
            flags_q <= '0;
            cnt_q   <= '0;
        end else if (accept) begin
            valid_q <= 1'b1;
            alu_q   <= res_d;
            addr_q  <= address;
            sd_q    <= store_data;
            ra_q    <= reg_addr;
            wr_q    <= write_reg & (opcode != OP_CMP);
            rd_q    <= (mem_op == 2'd1);
            we_q    <= (mem_op == 2'd2);
            pc_q    <= taken_d & is_branch;
            if (upd_d) flags_q <= flags_d;
            if (taken_d & is_branch) cnt_q <= cnt_q + 16'd1;
        end else if (out_ready | flush) begin
            valid_q <= 1'b0;
        end
    end

    assign out_valid    = valid_q;
    assign alu_out      = alu_q;
    assign address_o    = addr_q;
    assign store_data_o = sd_q;
    assign pctarget     = sd_q;
    assign reg_addr_o   = ra_q;
    assign write_reg_o  = wr_q;
    assign read_en      = rd_q & valid_q;
    assign write_en     = we_q & valid_q;
    assign pcsrc        = pc_q & valid_q;
    assign flags_o      = flags_q;
    assign taken_cnt    = cnt_q;

`ifdef EXEC_SEG_EN
    logic [8*NDIGIT-1:0] seg_q;

    function automatic logic [7:0] seg_enc(input logic [3:0] n);
        case (n)
            4'h0: return 8'hFC;  4'h1: return 8'h60;  4'h2: return 8'hDA;  4'h3: return 8'hF2;
            4'h4: return 8'h66;  4'h5: return 8'hB6;  4'h6: return 8'hBE;  4'h7: return 8'hE0;
            4'h8: return 8'hFE;  4'h9: return 8'hF6;  4'hA: return 8'hEE;  4'hB: return 8'h3E;
            4'hC: return 8'h1A;  4'hD: return 8'h7A;  4'hE: return 8'h9E;  default: return 8'h8E;
        endcase
    endfunction

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            seg_q <= {NDIGIT{8'hFC}};
        end else if (accept && opcode == OP_OUT) begin
            for (int unsigned i = 0; i < NDIGIT; i++) begin
                seg_q[8*i +: 8] <= seg_enc(alu1[4*i +: 4]);
            end
        end
    end

    assign seg = seg_q;
`else
    assign seg = '0;
`endif

endmodule

// File: tb/tb_exec_stage.sv
// Randomised and directed bench for exec_stage against an arithmetic reference model.
module tb_exec_stage;
    localparam int W  = 16;
    localparam int RA = 3;
    localparam int ND = W / 4;
    localparam int VW = 2 + 4*W + RA + 4 + 4 + 16 + 8*ND;

    logic clk = 1'b0, rst_n = 1'b0;
    logic in_valid = 1'b0, in_ready;
    logic [W-1:0] alu1 = '0, alu2 = '0, address = '0, store_data = '0;
    logic [3:0] opcode = '0;
    logic [2:0] cond = '0;
    logic is_branch = 1'b0, write_reg = 1'b0, flush = 1'b0, out_ready = 1'b0;
    logic [RA-1:0] reg_addr = '0;
    logic [1:0] mem_op = '0;
    logic out_valid, write_reg_o, read_en, write_en, pcsrc;
    logic [W-1:0] alu_out, address_o, store_data_o, pctarget;
    logic [RA-1:0] reg_addr_o;
    logic [3:0] flags_o;
    logic [15:0] taken_cnt;
    logic [8*ND-1:0] seg;

    exec_stage #(.WIDTH(W), .RA_W(RA)) dut (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
        .alu1(alu1), .alu2(alu2), .opcode(opcode), .cond(cond), .is_branch(is_branch),
        .write_reg(write_reg), .reg_addr(reg_addr), .mem_op(mem_op), .address(address),
        .store_data(store_data), .flush(flush), .out_valid(out_valid), .out_ready(out_ready),
        .alu_out(alu_out), .address_o(address_o), .store_data_o(store_data_o),
        .pctarget(pctarget), .reg_addr_o(reg_addr_o), .write_reg_o(write_reg_o),
        .read_en(read_en), .write_en(write_en), .pcsrc(pcsrc), .flags_o(flags_o),
        .taken_cnt(taken_cnt), .seg(seg)
    );

    always #5 clk = ~clk;

    int total = 0;
    int bad = 0;

    // Reference model state
    logic m_valid, m_wr, m_rd, m_we, m_pc;
    logic [W-1:0] m_alu, m_addr, m_sd;
    logic [RA-1:0] m_ra;
    logic [3:0] m_flags;
    logic [15:0] m_cnt;
    logic [8*ND-1:0] m_seg;

    logic [7:0] segtab [16] = '{8'hFC, 8'h60, 8'hDA, 8'hF2, 8'h66, 8'hB6, 8'hBE, 8'hE0,
                                8'hFE, 8'hF6, 8'hEE, 8'h3E, 8'h1A, 8'h7A, 8'h9E, 8'h8E};

    logic [VW-1:0] dut_vec;
    assign dut_vec = {out_valid, in_ready, alu_out, address_o, store_data_o, pctarget,
                      reg_addr_o, write_reg_o, read_en, write_en, pcsrc, flags_o, taken_cnt, seg};

    function automatic logic [VW-1:0] exp_now();
        return {m_valid, (!m_valid || out_ready), m_alu, m_addr, m_sd, m_sd, m_ra, m_wr,
                (m_rd && m_valid), (m_we && m_valid), (m_pc && m_valid), m_flags, m_cnt, m_seg};
    endfunction

    task automatic model_reset();
        m_valid = 1'b0; m_wr = 1'b0; m_rd = 1'b0; m_we = 1'b0; m_pc = 1'b0;
        m_alu = '0; m_addr = '0; m_sd = '0; m_ra = '0; m_flags = '0; m_cnt = '0;
`ifdef EXEC_SEG_EN
        m_seg = {ND{8'hFC}};
`else
        m_seg = '0;
`endif
    endtask

    task automatic model_edge();
        logic acc, s, z, v, tk, c, ov, upd;
        int sa, sb, sr;
        int unsigned ua, ub, ur;
        logic [W-1:0] r;
        acc = in_valid && (!m_valid || out_ready) && !flush;
        if (!acc) begin
            if (out_ready || flush) m_valid = 1'b0;
            return;
        end
        s = m_flags[3]; z = m_flags[2]; v = m_flags[0];
        case (cond)
            3'd0: tk = z;
            3'd1: tk = s ^ v;
            3'd2: tk = z | (s ^ v);
            3'd3: tk = !z;
            3'd4: tk = 1'b1;
            3'd5: tk = !(s ^ v);
            default: tk = 1'b0;
        endcase
        ua = alu1; ub = alu2; sa = $signed(alu1); sb = $signed(alu2);
        c = 1'b0; ov = 1'b0; upd = 1'b0; r = '0; ur = 0; sr = 0;
        case (opcode)
            4'd0: begin
                ur = ua + ub; r = ur[W-1:0]; c = (ur >= 32'd65536);
                sr = sa + sb; ov = (sr > 32767) || (sr < -32768); upd = 1'b1;
            end
            4'd1, 4'd5: begin
                ur = ua - ub; r = ur[W-1:0]; c = (ua < ub);
                sr = sa - sb; ov = (sr > 32767) || (sr < -32768); upd = 1'b1;
            end
            4'd2: begin r = alu1 & alu2; upd = 1'b1; end
            4'd3: begin r = alu1 | alu2; upd = 1'b1; end
            4'd4: begin r = alu1 ^ alu2; upd = 1'b1; end
            4'd8: begin ur = ua * (32'd1 << alu2[3:0]); r = ur[W-1:0]; upd = 1'b1; end
            4'd9: begin ur = ua / (32'd1 << alu2[3:0]); r = ur[W-1:0]; upd = 1'b1; end
            4'd6: r = alu2;
            4'd13: r = alu1;
            default: r = '0;
        endcase
        if (upd) m_flags = {r[W-1], (r == 0), c, ov};
        m_valid = 1'b1;
        m_alu = r; m_addr = address; m_sd = store_data; m_ra = reg_addr;
        m_wr = write_reg && (opcode != 4'd5);
        m_rd = (mem_op == 2'd1);
        m_we = (mem_op == 2'd2);
        m_pc = tk && is_branch;
        if (tk && is_branch) m_cnt = m_cnt + 16'd1;
`ifdef EXEC_SEG_EN
        if (opcode == 4'd13)
            for (int i = 0; i < ND; i++) m_seg[8*i +: 8] = segtab[alu1[4*i +: 4]];
`endif
    endtask

    task automatic cycle();
        model_edge();
        @(posedge clk);
        #1;
    endtask

    task automatic set_instr(input logic [3:0] op, input logic [W-1:0] a, input logic [W-1:0] b,
                             input logic [2:0] cd, input logic br, input logic wr,
                             input logic [1:0] mop, input logic [W-1:0] sd);
        opcode = op; alu1 = a; alu2 = b; cond = cd; is_branch = br; write_reg = wr;
        mem_op = mop; store_data = sd;
        reg_addr = RA'($urandom); address = W'($urandom);
        in_valid = 1'b1;
    endtask

    function automatic logic [W-1:0] pick();
        case ($urandom_range(0, 7))
            0: return 16'h0000;
            1: return 16'h7FFF;
            2: return 16'h8000;
            3: return 16'hFFFF;
            default: return W'($urandom);
        endcase
    endfunction

    task automatic test_reset();
        model_reset();
        out_ready = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        if (dut_vec !== exp_now()) begin
            bad++; $display("FAIL reset_vec got=%h want=%h", dut_vec, exp_now());
        end
        total++;
        if (in_ready !== 1'b1 || out_valid !== 1'b0) begin
            bad++; $display("FAIL reset_ready got in_ready=%b out_valid=%b want 1/0", in_ready, out_valid);
        end
        total++;
        rst_n = 1'b1;
        cycle();
        if (dut_vec !== exp_now()) begin
            bad++; $display("FAIL reset_idle got=%h want=%h", dut_vec, exp_now());
        end
        total++;
    endtask

    task automatic test_add_overflow();
        out_ready = 1'b1;
        set_instr(4'd0, 16'h7FFF, 16'h0001, 3'd6, 1'b0, 1'b1, 2'd0, 16'h0000);
        cycle();
        in_valid = 1'b0;
        if (alu_out !== 16'h8000 || flags_o !== 4'b1001 || out_valid !== 1'b1) begin
            bad++; $display("FAIL add_ovf got alu=%h flags=%b valid=%b want 8000/1001/1", alu_out, flags_o, out_valid);
        end
        total++;
        if (dut_vec !== exp_now()) begin
            bad++; $display("FAIL add_vec got=%h want=%h", dut_vec, exp_now());
        end
        total++;
    endtask

    task automatic test_branch();
        out_ready = 1'b1;
        set_instr(4'd5, 16'h0005, 16'h0005, 3'd6, 1'b0, 1'b1, 2'd0, 16'h0000);
        cycle();
        if (write_reg_o !== 1'b0 || flags_o[2] !== 1'b1) begin
            bad++; $display("FAIL cmp got wr=%b z=%b want 0/1", write_reg_o, flags_o[2]);
        end
        total++;
        set_instr(4'd6, 16'h0000, 16'h0000, 3'd0, 1'b1, 1'b0, 2'd0, 16'h0040);
        cycle();
        in_valid = 1'b0;
        if (pcsrc !== 1'b1 || pctarget !== 16'h0040 || taken_cnt !== 16'd1) begin
            bad++; $display("FAIL branch got pcsrc=%b tgt=%h cnt=%0d want 1/0040/1", pcsrc, pctarget, taken_cnt);
        end
        total++;
        if (dut_vec !== exp_now()) begin
            bad++; $display("FAIL branch_vec got=%h want=%h", dut_vec, exp_now());
        end
        total++;
    endtask

    task automatic test_backpressure();
        out_ready = 1'b1;
        set_instr(4'd4, 16'h00F0, 16'h0F0F, 3'd6, 1'b0, 1'b1, 2'd1, 16'h1234);
        cycle();
        set_instr(4'd1, 16'h0010, 16'h0003, 3'd6, 1'b0, 1'b1, 2'd0, 16'h5678);
        out_ready = 1'b0;
        for (int i = 0; i < 3; i++) begin
            cycle();
            if (in_ready !== 1'b0 || alu_out !== 16'h0FFF) begin
                bad++; $display("FAIL stall%0d got in_ready=%b alu=%h want 0/0FFF", i, in_ready, alu_out);
            end
            total++;
            if (dut_vec !== exp_now()) begin
                bad++; $display("FAIL stall_vec%0d got=%h want=%h", i, dut_vec, exp_now());
            end
            total++;
        end
        out_ready = 1'b1;
        cycle();
        in_valid = 1'b0;
        if (alu_out !== 16'h000D || out_valid !== 1'b1 || store_data_o !== 16'h5678) begin
            bad++; $display("FAIL release got alu=%h valid=%b sd=%h want 000D/1/5678", alu_out, out_valid, store_data_o);
        end
        total++;
    endtask

    task automatic test_flush();
        logic [3:0] fl0;
        logic [15:0] cn0;
        fl0 = m_flags; cn0 = m_cnt;
        out_ready = 1'b1;
        set_instr(4'd0, 16'h8000, 16'h8000, 3'd4, 1'b1, 1'b1, 2'd0, 16'h0100);
        flush = 1'b1;
        cycle();
        flush = 1'b0; in_valid = 1'b0;
        if (out_valid !== 1'b0 || flags_o !== fl0 || taken_cnt !== cn0) begin
            bad++; $display("FAIL flush got valid=%b flags=%b cnt=%0d want 0/%b/%0d", out_valid, flags_o, taken_cnt, fl0, cn0);
        end
        total++;
        if (dut_vec !== exp_now()) begin
            bad++; $display("FAIL flush_vec got=%h want=%h", dut_vec, exp_now());
        end
        total++;
    endtask

    task automatic test_mem_write();
        out_ready = 1'b1;
        set_instr(4'd6, 16'h0000, 16'hBEEF, 3'd6, 1'b0, 1'b0, 2'd2, 16'hBEEF);
        cycle();
        in_valid = 1'b0; out_ready = 1'b0;
        for (int i = 0; i < 2; i++) begin
            cycle();
            if (write_en !== 1'b1 || read_en !== 1'b0) begin
                bad++; $display("FAIL wr_hold%0d got we=%b re=%b want 1/0", i, write_en, read_en);
            end
            total++;
        end
        out_ready = 1'b1;
        cycle();
        if (write_en !== 1'b0 || out_valid !== 1'b0) begin
            bad++; $display("FAIL wr_drop got we=%b valid=%b want 0/0", write_en, out_valid);
        end
        total++;
    endtask

    task automatic test_seg_reset();
        logic [8*ND-1:0] want;
        out_ready = 1'b1;
        set_instr(4'd13, 16'h12AF, 16'h0000, 3'd6, 1'b0, 1'b0, 2'd0, 16'h0000);
        cycle();
`ifdef EXEC_SEG_EN
        want = 32'h60DAEE8E;
`else
        want = '0;
`endif
        if (seg !== want || alu_out !== 16'h12AF) begin
            bad++; $display("FAIL seg_out got seg=%h alu=%h want %h/12AF", seg, alu_out, want);
        end
        total++;
        set_instr(4'd0, 16'h0001, 16'h0002, 3'd4, 1'b1, 1'b1, 2'd1, 16'h0000);
        cycle();
        #3;
        rst_n = 1'b0;
        model_reset();
        #1;
`ifdef EXEC_SEG_EN
        want = 32'hFCFCFCFC;
`else
        want = '0;
`endif
        if (out_valid !== 1'b0 || seg !== want || taken_cnt !== 16'd0 || read_en !== 1'b0) begin
            bad++; $display("FAIL async_rst got valid=%b seg=%h cnt=%0d re=%b want 0/%h/0/0", out_valid, seg, taken_cnt, read_en, want);
        end
        total++;
        if (dut_vec !== exp_now()) begin
            bad++; $display("FAIL async_rst_vec got=%h want=%h", dut_vec, exp_now());
        end
        total++;
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        in_valid = 1'b0;
    endtask

    task automatic test_random();
        for (int i = 0; i < 400; i++) begin
            opcode = 4'($urandom_range(0, 15));
            alu1 = pick();
            alu2 = pick();
            cond = 3'($urandom_range(0, 7));
            is_branch = 1'($urandom_range(0, 1));
            write_reg = 1'($urandom_range(0, 1));
            reg_addr = RA'($urandom);
            mem_op = 2'($urandom);
            address = W'($urandom);
            store_data = W'($urandom);
            in_valid = ($urandom_range(0, 9) < 7);
            out_ready = ($urandom_range(0, 3) != 0);
            flush = ($urandom_range(0, 9) == 0);
            cycle();
            if (dut_vec !== exp_now()) begin
                bad++; $display("FAIL rand%0d got=%h want=%h", i, dut_vec, exp_now());
            end
            total++;
        end
        in_valid = 1'b0; flush = 1'b0;
    endtask

    initial begin
        test_reset();
        test_add_overflow();
        test_branch();
        test_backpressure();
        test_flush();
        test_mem_write();
        test_seg_reset();
        test_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
